// File: rtl/prbs_pkg.sv
// Shared definitions for the 64-bit PRBS stream generator/checker pair.
// Holds the polynomial taps, the one-step LFSR function and the checker state encoding.
// Pure definitions: no timing, no flow control.
package prbs_pkg;

    // Feedback taps of the 64-bit stream LFSR: new bit 0 = x[63] ^ x[2] ^ x[0].
    localparam int POLY_TAPS [0:2] = '{63, 2, 0};

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    // One generator step; the all-zero word maps to itself (lockup state).
    function automatic logic [63:0] lfsr_step(input logic [63:0] x);
        return {x[62:0], x[POLY_TAPS[0]] ^ x[POLY_TAPS[1]] ^ x[POLY_TAPS[2]]};
    endfunction

endpackage

// File: rtl/prbs_stream_checker_if.sv
// Stream-side bundle of the PRBS checker: word input, clear and status/counter outputs.
// Carries no timing of its own; the checker samples on its clock.
// No backpressure: the source presents a word with in_valid whenever it likes.
interface prbs_stream_checker_if #(
    parameter int ERR_W = 16
) ();

    logic              in_valid;
    logic [63:0]       in_data;
    logic              clear;
    logic              locked;
    logic              err_pulse;
    logic [ERR_W-1:0]  err_count;
    logic [31:0]       word_count;
    logic [63:0]       sig;

    // Stream source / bench side.
    modport master (
        output in_valid, in_data, clear,
        input  locked, err_pulse, err_count, word_count, sig
    );

    // Checker side.
    modport slave (
        input  in_valid, in_data, clear,
        output locked, err_pulse, err_count, word_count, sig
    );

endinterface

// File: rtl/prbs_misr.sv
// 64-bit multiple-input signature register built on the stream LFSR step.
// Latency: one cycle from en/clr to the updated signature.
// No backpressure: every enabled cycle folds in one word; clr overrides en.
module prbs_misr
    import prbs_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        clr,
    input  logic [63:0] data,
    output logic [63:0] sig
);

    logic [63:0] sig_q;
    logic [63:0] sig_d;

    // Next signature: clear wins, otherwise fold the word into the stepped signature.
    always_comb begin
        sig_d = sig_q;
        if (clr) begin
            sig_d = '0;
        end else if (en) begin
            sig_d = data ^ lfsr_step(sig_q);
        end
    end

    // Signature register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/prbs_stream_checker.sv
// Self-synchronising checker for the 64-bit LFSR stream: lock, flywheel verify, error/word counts, MISR.
// Latency: one cycle from a sampled word to the locked/err_pulse/counter/sig update.
// No backpressure: every in_valid word is consumed; idle cycles only drop err_pulse.
module prbs_stream_checker
    import prbs_pkg::*;
#(
    parameter int LOCK_CNT = 8,
    parameter int LOSS_CNT = 4,
    parameter int ERR_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    prbs_stream_checker_if.slave bus
);

    localparam int MC_W = $clog2(LOCK_CNT + 1);
    localparam int MS_W = $clog2(LOSS_CNT + 1);

    state_t            state_q, state_d;
    logic [63:0]       exp_q, exp_d;
    logic [MC_W-1:0]   match_cnt_q, match_cnt_d;
    logic [MS_W-1:0]   miss_cnt_q, miss_cnt_d;
    logic              locked_q, locked_d;
    logic              err_pulse_q, err_pulse_d;
    logic [ERR_W-1:0]  err_count_q, err_count_d;
    logic [31:0]       word_count_q, word_count_d;

    logic              word_hit;
    logic              data_zero;
    logic [MC_W-1:0]   match_inc;
    logic [MS_W-1:0]   miss_inc;
    logic              misr_en;

    assign word_hit  = (bus.in_data == exp_q);
    assign data_zero = (bus.in_data == 64'd0);
    assign match_inc = match_cnt_q + MC_W'(1);
    assign miss_inc  = miss_cnt_q + MS_W'(1);
    assign misr_en   = bus.in_valid && (state_q == LOCKED);

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= HUNT;
            exp_q        <= '0;
            match_cnt_q  <= '0;
            miss_cnt_q   <= '0;
            locked_q     <= 1'b0;
            err_pulse_q  <= 1'b0;
            err_count_q  <= '0;
            word_count_q <= '0;
        end else begin
            state_q      <= state_d;
            exp_q        <= exp_d;
            match_cnt_q  <= match_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
            locked_q     <= locked_d;
            err_pulse_q  <= err_pulse_d;
            err_count_q  <= err_count_d;
            word_count_q <= word_count_d;
        end
    end

    // Next state: acquire on a nonzero seed, lock after LOCK_CNT matches, drop after LOSS_CNT misses.
    always_comb begin
        state_d = state_q;
        if (bus.in_valid) begin
            case (state_q)
                HUNT: begin
                    if (!data_zero) state_d = VERIFY;
                end
                VERIFY: begin
                    if (word_hit) begin
                        if (match_inc == MC_W'(LOCK_CNT)) state_d = LOCKED;
                    end else if (data_zero) begin
                        state_d = HUNT;
                    end
                end
                LOCKED: begin
                    if (!word_hit && (miss_inc == MS_W'(LOSS_CNT))) state_d = HUNT;
                end
                default: state_d = HUNT;
            endcase
        end
    end

    // Prediction, run counters, error/word counters and registered status.
    always_comb begin
        exp_d        = exp_q;
        match_cnt_d  = match_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        err_pulse_d  = 1'b0;
        err_count_d  = err_count_q;
        word_count_d = word_count_q;
        locked_d     = (state_d == LOCKED);
        if (bus.in_valid) begin
            case (state_q)
                HUNT: begin
                    if (!data_zero) begin
                        exp_d       = lfsr_step(bus.in_data);
                        match_cnt_d = '0;
                    end
                end
                VERIFY: begin
                    // Both a hit and a reseed predict from the received word.
                    exp_d = lfsr_step(bus.in_data);
                    if (word_hit) begin
                        match_cnt_d = match_inc;
                        if (match_inc == MC_W'(LOCK_CNT)) miss_cnt_d = '0;
                    end else begin
                        match_cnt_d = '0;
                    end
                end
                LOCKED: begin
                    // Flywheel: corrupted words never steer the prediction.
                    exp_d = lfsr_step(exp_q);
                    if (word_count_q != '1) word_count_d = word_count_q + 32'd1;
                    if (word_hit) begin
                        miss_cnt_d = '0;
                    end else begin
                        err_pulse_d = 1'b1;
                        if (err_count_q != '1) err_count_d = err_count_q + ERR_W'(1);
                        miss_cnt_d = miss_inc;
                        if (miss_inc == MS_W'(LOSS_CNT)) match_cnt_d = '0;
                    end
                end
                default: begin
                    exp_d = '0;
                end
            endcase
        end
        if (bus.clear) begin
            err_count_d  = '0;
            word_count_d = '0;
        end
    end

    prbs_misr u_misr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (misr_en),
        .clr   (bus.clear),
        .data  (bus.in_data),
        .sig   (bus.sig)
    );

    assign bus.locked     = locked_q;
    assign bus.err_pulse  = err_pulse_q;
    assign bus.err_count  = err_count_q;
    assign bus.word_count = word_count_q;

endmodule

// File: tb/tb_prbs_stream_checker.sv
// Bench for prbs_stream_checker: directed lock/loss/clear/reset phases plus random gaps and faults.
// Outputs are compared every negedge against a chain-length model of the stream rules.
// Inputs change 1 time unit after posedge; the checker never backpressures.
module tb_prbs_stream_checker;
    import prbs_pkg::*;

    localparam int LOCK_CNT = 8;
    localparam int LOSS_CNT = 4;
    localparam int ERR_W    = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    prbs_stream_checker_if #(.ERR_W(ERR_W)) bus ();

    prbs_stream_checker #(
        .LOCK_CNT (LOCK_CNT),
        .LOSS_CNT (LOSS_CNT),
        .ERR_W    (ERR_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;
    bit checking = 1'b0;

    // Reference model: lock = a run of LOCK_CNT+1 valid words each the step of the last.
    bit               m_locked = 1'b0;
    bit               m_pulse  = 1'b0;
    logic [ERR_W-1:0] m_err    = '0;
    logic [31:0]      m_words  = '0;
    logic [63:0]      m_sig    = '0;
    logic [63:0]      m_prev   = '0;
    logic [63:0]      m_fly    = '0;
    int               m_chain  = 0;
    int               m_miss   = 0;

    logic [63:0] gen;

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_locked = 0; m_pulse = 0; m_err = '0; m_words = '0; m_sig = '0;
            m_prev = '0; m_fly = '0; m_chain = 0; m_miss = 0;
        end else begin
            m_pulse = 0;
            if (bus.in_valid) begin
                if (!m_locked) begin
                    if (bus.in_data == 64'd0)                                m_chain = 0;
                    else if (m_chain > 0 && bus.in_data == lfsr_step(m_prev)) m_chain++;
                    else                                                     m_chain = 1;
                    m_prev = bus.in_data;
                    if (m_chain == LOCK_CNT + 1) begin
                        m_locked = 1; m_fly = lfsr_step(bus.in_data); m_miss = 0;
                    end
                end else begin
                    m_words = (m_words == 32'hFFFF_FFFF) ? m_words : m_words + 1;
                    m_sig   = bus.in_data ^ lfsr_step(m_sig);
                    if (bus.in_data == m_fly) begin
                        m_miss = 0;
                    end else begin
                        m_pulse = 1;
                        m_err   = (m_err == '1) ? m_err : m_err + 1'b1;
                        m_miss++;
                        if (m_miss == LOSS_CNT) begin m_locked = 0; m_chain = 0; end
                    end
                    m_fly = lfsr_step(m_fly);
                end
            end
            if (bus.clear) begin m_err = '0; m_words = '0; m_sig = '0; end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (checking) begin
            check64("locked",     64'(bus.locked),     64'(m_locked));
            check64("err_pulse",  64'(bus.err_pulse),  64'(m_pulse));
            check64("err_count",  64'(bus.err_count),  64'(m_err));
            check64("word_count", 64'(bus.word_count), 64'(m_words));
            check64("sig",        bus.sig,             m_sig);
        end
    end

    task automatic send(input bit v, input logic [63:0] d, input bit c);
        bus.in_valid = v; bus.in_data = d; bus.clear = c;
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.clear = 1'b0;
        bus.in_data  = {$urandom, $urandom};
    endtask

    task automatic clean(input bit c = 1'b0);
        send(1'b1, gen, c);
        gen = lfsr_step(gen);
    endtask

    task automatic bad();
        send(1'b1, gen ^ 64'h1, 1'b0);
        gen = lfsr_step(gen);
    endtask

    task automatic random_phase(input int n);
        int r;
        for (int i = 0; i < n; i++) begin
            r = $urandom_range(0, 99);
            if (r < 50)      send(1'b0, 64'd0, 1'b0);
            else if (r < 53) bad();
            else if (r < 55) send(1'b0, 64'd0, 1'b1);
            else             clean();
        end
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.in_data = '0; bus.clear = 1'b0;

        check64("step_1", lfsr_step(64'h1), 64'h3);
        check64("step_3", lfsr_step(64'h3), 64'h7);
        check64("step_7", lfsr_step(64'h7), 64'hE);
        check64("step_E", lfsr_step(64'hE), 64'h1D);

        checking = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check64("reset_locked", 64'(bus.locked), 64'd0);
        check64("reset_sig",    bus.sig,         64'd0);
        rst_n = 1'b1;
        repeat (2) send(1'b0, 64'd0, 1'b0);

        // Zero words never seed.
        repeat (3) send(1'b1, 64'd0, 1'b0);
        check64("zero_hunt", 64'(bus.locked), 64'd0);

        // 1, 3, 7, E, ...: seed plus 8 matches.
        gen = 64'h1;
        repeat (LOCK_CNT) clean();
        check64("pre_lock", 64'(bus.locked), 64'd0);
        clean();
        check64("lock_9th", 64'(bus.locked), 64'd1);
        check64("lock_err", 64'(bus.err_count), 64'd0);

        // Four consecutive corrupted words drop lock on the fourth.
        repeat (LOSS_CNT - 1) bad();
        check64("loss_hold", 64'(bus.locked), 64'd1);
        bad();
        check64("loss_drop", 64'(bus.locked), 64'd0);
        check64("loss_err",  64'(bus.err_count), 64'd4);

        // Relock on a new seed; counters survive.
        gen = 64'h5aef0c8d_d70a4497;
        repeat (LOCK_CNT) clean();
        check64("relock_pre", 64'(bus.locked), 64'd0);
        clean();
        check64("relock",     64'(bus.locked), 64'd1);
        check64("relock_err", 64'(bus.err_count), 64'd4);

        // Single bit-0 flip.
        bad();
        check64("flip_pulse",  64'(bus.err_pulse), 64'd1);
        check64("flip_err",    64'(bus.err_count), 64'd5);
        check64("flip_locked", 64'(bus.locked),    64'd1);
        clean();
        check64("flip_pulse_end", 64'(bus.err_pulse), 64'd0);
        check64("flip_err_hold",  64'(bus.err_count), 64'd5);

        // Clear coincident with a locked word.
        repeat (3) clean();
        clean(1'b1);
        check64("clr_err",    64'(bus.err_count),  64'd0);
        check64("clr_words",  64'(bus.word_count), 64'd0);
        check64("clr_sig",    bus.sig,             64'd0);
        check64("clr_locked", 64'(bus.locked),     64'd1);

        // Drop lock, then reacquire and run under random gaps.
        repeat (LOSS_CNT) bad();
        random_phase(400);

        // Mid-stream asynchronous reset.
        repeat (3) clean();
        rst_n = 1'b0;
        #1;
        check64("arst_locked", 64'(bus.locked), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (LOCK_CNT) clean();
        check64("arst_pre", 64'(bus.locked), 64'd0);
        clean();
        check64("arst_relock", 64'(bus.locked), 64'd1);

        random_phase(300);

        @(negedge clk);
        checking = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/prbs_stream_checker.md
Name: prbs_stream_checker

Overview:
- Receive end of the 64-bit LFSR stimulus stream used by the regression benches. Generator step: next = {cur[62:0], cur[63]^cur[2]^cur[0]}.
- Self-synchronises to the incoming word stream, verifies each word against the predicted successor, and counts errors.
- Compresses accepted words into a 64-bit MISR signature so a bench can compare one final value.
- Sits between a DUT output and the bench's pass/fail logic.

Parameters:
- LOCK_CNT, 8: consecutive matching words needed to declare lock.
- LOSS_CNT, 4: consecutive mismatching words while locked that force loss of lock.
- ERR_W, 16: width of the error counter.

Ports:
- clk  input  1  sole clock; all state updates on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_data is sampled this cycle.
- in_data  input  64  stream word.
- clear  input  1  synchronous clear of err_count, word_count and sig.
- locked  output  1  high while the FSM is in LOCKED.
- err_pulse  output  1  one-cycle pulse per mismatched word while LOCKED.
- err_count  output  ERR_W  saturating count of mismatches while LOCKED.
- word_count  output  32  saturating count of valid words consumed while LOCKED.
- sig  output  64  MISR signature.

Behaviour:
- Reset (rst_n low, async): state=HUNT, exp=0, match_cnt=0, miss_cnt=0, locked=0, err_pulse=0, err_count=0, word_count=0, sig=0. All outputs are registered.
- step(x) = {x[62:0], x[63]^x[2]^x[0]}. step(0)=0 is the lockup state.
- A cycle with in_valid=0 changes nothing except that err_pulse returns to 0.
- HUNT, on valid:
  - in_data==0: stay in HUNT; zero is not a legal seed.
  - otherwise: exp<=step(in_data), match_cnt<=0, go to VERIFY.
- VERIFY, on valid:
  - in_data==exp: exp<=step(in_data), match_cnt++.
  - If that match makes match_cnt reach LOCK_CNT: go to LOCKED, locked=1 on the next cycle, miss_cnt<=0.
  - Mismatch: reseed exp<=step(in_data) (or return to HUNT if in_data==0), match_cnt<=0.
  - No error counting in HUNT or VERIFY.
- LOCKED, on valid:
  - exp<=step(exp) always (flywheel; the prediction does not follow corrupted data).
  - word_count++ (saturating).
  - sig <= in_data ^ step(sig).
  - Match: miss_cnt<=0.
  - Mismatch: err_pulse=1 on the next cycle, err_count++ (saturates at all-ones), miss_cnt++.
  - If miss_cnt reaches LOSS_CNT: go to HUNT, locked=0 on the next cycle, match_cnt<=0.
  - Counters and sig are not reset on loss of lock.
- Latency: one cycle from sampling a word to the matching locked, err_pulse or counter update.
- clear:
  - Zeroes err_count, word_count and sig in the next cycle.
  - If clear coincides with a valid LOCKED word: clear wins for counters and sig; the FSM, exp and err_pulse still advance normally.
  - Does not affect state.
- rst_n asserted mid-stream: immediate return to reset values; re-acquisition starts from HUNT.

Decomposition:
- Shared package prbs_pkg holds:
  - POLY_TAPS constant (63,2,0)
  - lfsr_step function
  - state enum {HUNT, VERIFY, LOCKED}
- The bench generator reuses lfsr_step from the same package.
- One natural sub-module, prbs_misr: 64-bit signature register with enable and clear, reusable by other benches.
- The FSM and counters stay in the top block.

Test Plan:
- Reset, no valid → locked=0, err_pulse=0, err_count=0, word_count=0, sig=0.
- Stream 64'h1, 64'h3, 64'h7, 64'hE, … (1 seed + 8 matches) → locked=1 the cycle after the 9th word; err_count=0. Feeding in_data=0 in HUNT leaves the FSM in HUNT.
- Locked on a stream seeded 64'h5aef0c8d_d70a4497; flip bit 0 of one word:
  - err_pulse high for exactly 1 cycle, err_count=1, locked stays 1.
  - The next uncorrupted word matches.
- While locked, corrupt 4 consecutive words → err_count=4, locked falls after the 4th word. A clean stream then relocks after 9 valid words; err_count stays 4.
- Random in_valid gaps (50% idle) on a clean stream:
  - Lock timing is measured in valid words, not cycles.
  - sig matches the bench model: sig = word ^ step(sig) per locked word.
- clear while locked → err_count=0, word_count=0, sig=0 next cycle; locked unchanged.
- rst_n pulsed low mid-stream → locked=0 asynchronously; relock requires a fresh HUNT/VERIFY sequence.
